circuit_sweep: RTL and testbench

Exhaustive stimulus-and-capture stage for the 3-input combinational circuit block (inputs a, b, c; output f).
- Drives all 8 input combinations in binary order and holds each for a programmable settle time.
- Samples f into an 8-bit truth-table register and compares it against an expected table.
- Sits directly upstream of the circuit (feeds a/b/c) and consumes its f; used for self-test in place of the manual vector bench.

---
 rtl/circuit_pkg.sv | 6 +
 rtl/settle_timer.sv | 18 +
 rtl/circuit_sweep.sv | 87 ++++++++
 tb/tb_circuit_sweep.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/circuit_pkg.sv
// circuit_pkg: shared FSM states and vector geometry for the exhaustive circuit sweep
package circuit_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int NUM_VECTORS = 8;
  localparam int VEC_W = 3;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: counts cycles a vector has been held and flags the sampling cycle
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic last
);
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign last = cnt_q == LAST;
  // restart at zero when idle or on each sample, else keep counting
  always_comb cnt_d = (clear || last) ? '0 : cnt_q + CW'(1);
  // hold-time counter register
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/circuit_sweep.sv
// circuit_sweep: drives all {a,b,c} vectors, captures f into a truth table and grades it
module circuit_sweep
  import circuit_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter logic [7:0] EXPECTED = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       f,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic [7:0] mismatch,
  output logic       pass
);
  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);
  if (SETTLE < 1) begin : g_bad_settle
    $error("circuit_sweep: SETTLE must be at least 1");
  end
  state_e state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [NUM_VECTORS-1:0] truth_q, truth_d;
  logic pass_q, pass_d, busy_q, done_q, last;
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state_q != RUN),
    .last (last)
  );
  // sweep sequencing: start from IDLE/DONE, capture each vector when its hold time ends
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    truth_d = truth_q;
    pass_d  = pass_q;
    case (state_q)
      RUN: begin
        if (last) begin
          truth_d[idx_q] = f;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            pass_d  = truth_d == EXPECTED;
          end else begin
            idx_d = idx_q + VEC_W'(1);
          end
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          truth_d = '0;
          pass_d  = 1'b0;
        end
      end
    endcase
  end
  // state, vector index, captured table and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      truth_q <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      truth_q <= truth_d;
      pass_q  <= pass_d;
      busy_q  <= state_d == RUN;
      done_q  <= state_d == DONE;
    end
  end
  assign {a, b, c} = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign truth     = truth_q;
  assign mismatch  = truth_q ^ EXPECTED;
  assign pass      = pass_q;
endmodule

// File: tb/tb_circuit_sweep.sv
// tb_circuit_sweep: scoreboard bench for circuit_sweep with behavioural and tied circuits
module tb_circuit_sweep;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start2 = 1'b0, start1 = 1'b0, f1 = 1'b0;
  logic a2, b2, c2, busy2, done2, pass2, a3, b3, c3, busy3, done3, pass3, a1, b1, c1, busy1, done1, pass1;
  logic [7:0] truth2, mis2, truth3, mis3, truth1, mis1;
  wire f2 = (a2 & b2) | c2;
  wire f3 = (a3 & b3) | c3;
  int total = 0, bad = 0;
  logic [7:0] exp2[$], exp3[$], exp1[$];
  logic [7:0] e;
  always #5 clk = ~clk;
  circuit_sweep #(.SETTLE(2), .EXPECTED(8'hEA)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .f(f2), .a(a2), .b(b2), .c(c2),
    .busy(busy2), .done(done2), .truth(truth2), .mismatch(mis2), .pass(pass2));
  circuit_sweep #(.SETTLE(2), .EXPECTED(8'hE8)) dut3 (
    .clk(clk), .reset(reset), .start(start2), .f(f3), .a(a3), .b(b3), .c(c3),
    .busy(busy3), .done(done3), .truth(truth3), .mismatch(mis3), .pass(pass3));
  circuit_sweep #(.SETTLE(1), .EXPECTED(8'hFF)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .f(f1), .a(a1), .b(b1), .c(c1),
    .busy(busy1), .done(done1), .truth(truth1), .mismatch(mis1), .pass(pass1));
  task automatic check_idle2(input string name);
    total++;
    if ({a2, b2, c2, busy2, done2, truth2, pass2} !== 13'd0) begin
      bad++;
      $display("FAIL %s: abc=%b busy=%b done=%b truth=%h pass=%b, want all zero", name,
               {a2, b2, c2}, busy2, done2, truth2, pass2);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle2("reset_state");
    repeat (3) @(negedge clk);
    check_idle2("idle_hold");
    total++;
    if ({busy3, done3, truth3, busy1, done1, truth1} !== 20'd0) begin
      bad++;
      $display("FAIL reset_others: dut3 busy/done/truth=%b/%b/%h dut1=%b/%b/%h want 0", busy3, done3, truth3,
               busy1, done1, truth1);
    end
  endtask
  task automatic run_sweep(input int p1, input int p2, input bit chk3);
    @(negedge clk);
    start2 = 1'b1;
    exp2.push_back(8'hEA);
    if (chk3) exp3.push_back(8'hEA);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      start2 = (j == p1) || (j == p2);
      total++;
      if ({a2, b2, c2} !== 3'((j - 1) / 2) || busy2 !== 1'b1 || done2 !== 1'b0) begin
        bad++;
        $display("FAIL sweep_step%0d: abc=%b busy=%b done=%b, want abc=%0d busy=1 done=0", j, {a2, b2, c2},
                 busy2, done2, (j - 1) / 2);
      end
    end
    @(negedge clk);
    total++;
    if (exp2.size() == 0) begin
      bad++;
      $display("FAIL sweep_sb2: no expected entry queued");
    end else begin
      e = exp2.pop_front();
      if (done2 !== 1'b1 || busy2 !== 1'b0 || {a2, b2, c2} !== 3'b111 || truth2 !== e || mis2 !== (e ^ 8'hEA) ||
          pass2 !== (e == 8'hEA)) begin
        bad++;
        $display("FAIL sweep_done2: done=%b busy=%b abc=%b truth=%h mis=%h pass=%b want 1 0 111 %h %h %b", done2,
                 busy2, {a2, b2, c2}, truth2, mis2, pass2, e, e ^ 8'hEA, e == 8'hEA);
      end
    end
    if (chk3) begin
      total++;
      if (exp3.size() == 0) begin
        bad++;
        $display("FAIL sweep_sb3: no expected entry queued");
      end else begin
        e = exp3.pop_front();
        if (done3 !== 1'b1 || truth3 !== e || mis3 !== (e ^ 8'hE8) || pass3 !== (e == 8'hE8)) begin
          bad++;
          $display("FAIL sweep_done3: done=%b truth=%h mis=%h pass=%b want 1 %h %h %b", done3, truth3, mis3, pass3,
                   e, e ^ 8'hE8, e == 8'hE8);
        end
      end
    end
    repeat (2) @(negedge clk);
    total++;
    if (done2 !== 1'b1 || truth2 !== 8'hEA || {a2, b2, c2} !== 3'b111) begin
      bad++;
      $display("FAIL done_hold: done=%b truth=%h abc=%b want 1 ea 111", done2, truth2, {a2, b2, c2});
    end
  endtask
  task automatic test_sweep_match;
    run_sweep(0, 0, 1'b1);
  endtask
  task automatic test_ignore_start;
    run_sweep(3, 9, 1'b0);
  endtask
  task automatic test_reset_abort;
    @(negedge clk);
    start2 = 1'b1;
    exp2.push_back(8'hEA);
    repeat (7) @(negedge clk);
    start2 = 1'b0;
    total++;
    if ({a2, b2, c2} !== 3'd3) begin
      bad++;
      $display("FAIL abort_pre: abc=%b want 011", {a2, b2, c2});
    end
    reset = 1'b1;
    exp2.delete();
    @(negedge clk);
    reset = 1'b0;
    check_idle2("abort_reset");
    run_sweep(0, 0, 1'b0);
  endtask
  task automatic test_settle1;
    f1 = 1'b1;
    @(negedge clk);
    start1 = 1'b1;
    exp1.push_back(8'hFF);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      start1 = 1'b0;
      total++;
      if (busy1 !== 1'b1 || done1 !== 1'b0 || {a1, b1, c1} !== 3'(j - 1)) begin
        bad++;
        $display("FAIL s1_step%0d: busy=%b done=%b abc=%b want 1 0 %0d", j, busy1, done1, {a1, b1, c1}, j - 1);
      end
    end
    @(negedge clk);
    total++;
    e = exp1.pop_front();
    if (done1 !== 1'b1 || truth1 !== e || pass1 !== 1'b1) begin
      bad++;
      $display("FAIL s1_done: done=%b truth=%h pass=%b want 1 %h 1", done1, truth1, pass1, e);
    end
    f1 = 1'b0;
    start1 = 1'b1;
    exp1.push_back(8'h00);
    @(negedge clk);
    start1 = 1'b0;
    total++;
    if (truth1 !== 8'h00 || done1 !== 1'b0 || busy1 !== 1'b1 || pass1 !== 1'b0) begin
      bad++;
      $display("FAIL s1_restart: truth=%h done=%b busy=%b pass=%b want 00 0 1 0", truth1, done1, busy1, pass1);
    end
    repeat (8) @(negedge clk);
    total++;
    e = exp1.pop_front();
    if (done1 !== 1'b1 || truth1 !== e || pass1 !== 1'b0 || mis1 !== 8'hFF) begin
      bad++;
      $display("FAIL s1_done2: done=%b truth=%h pass=%b mis=%h want 1 %h 0 ff", done1, truth1, pass1, mis1, e);
    end
  endtask
  initial begin
    test_reset();
    test_sweep_match();
    test_ignore_start();
    test_reset_abort();
    test_settle1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
